// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller feeding a combinational 12-bit ALU from a 4-entry register file
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [1:0]  ld_addr,
  input  logic [11:0] ld_data,
  output logic        ld_ready,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_opcode,
  output logic [11:0] alu_op1,
  output logic [11:0] alu_op2,
  input  logic [11:0] alu_out,
  output logic        res_valid,
  output logic [11:0] res_data,
  output logic [1:0]  res_rd,
  input  logic        res_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t      state_q, state_d;
  logic [11:0] regs_q [4];
  logic [2:0]  opc_q, alu_opcode_q;
  logic [1:0]  rd_q, rs1_q, rs2_q;
  logic [11:0] op1_q, op2_q, res_q;
  logic        unused_rsvd;
  assign unused_rsvd = ^instr[2:0];
  assign ld_ready    = state_q == IDLE;
  assign instr_ready = state_q == IDLE && !ld_valid;
  assign busy        = state_q != IDLE;
  assign res_valid   = state_q == WB;
  assign res_data    = res_q;
  assign res_rd      = rd_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  // next state: preload blocks issue, READ and EXEC are single-cycle, WB waits for the consumer
  always_comb begin
    state_d = state_q == IDLE ? (instr_valid && !ld_valid ? READ : IDLE) :
              state_q == READ ? EXEC :
              state_q == EXEC ? WB :
              (res_ready ? IDLE : WB);
  end
  // state, register file, operand latches and result capture; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      regs_q       <= '{default: '0};
      opc_q        <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      alu_opcode_q <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      res_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ld_valid) regs_q[ld_addr] <= ld_data;
          else if (instr_valid) {opc_q, rd_q, rs1_q, rs2_q} <= instr[11:3];
        end
        READ: begin
          alu_opcode_q <= opc_q;
          op1_q        <= regs_q[rs1_q];
          op2_q        <= regs_q[rs2_q];
        end
        EXEC: begin
          res_q         <= alu_out;
          regs_q[rd_q]  <= alu_out;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed timeline-driven bench with a register-file model and per-cycle output checks
module tb_alu_sequencer;
  logic        clk = 0, rst_n = 0, ld_valid = 0, instr_valid = 0, res_ready = 0;
  logic [1:0]  ld_addr = 0;
  logic [11:0] ld_data = 0, instr = 0, alu_out;
  logic        ld_ready, instr_ready, res_valid, busy;
  logic [2:0]  alu_opcode;
  logic [11:0] alu_op1, alu_op2, res_data;
  logic [1:0]  res_rd;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, last_acc = 0, prev_acc = 0;
  logic [11:0] m [4];
  logic        chk_en = 0, in_exec = 0, exp_busy = 0, exp_rv = 0;
  logic [2:0]  exp_opc = 0;
  logic [11:0] exp_op1 = 0, exp_op2 = 0, exp_res = 0, ex_op1 = 0, ex_op2 = 0, last_res = 0;
  logic [1:0]  exp_rd = 0;

  function automatic logic [11:0] alu_f(logic [2:0] o, logic [11:0] a, logic [11:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a;
      3'd6: return a << 1;
      default: return ~a;
    endcase
  endfunction

  // ALU stub: only meaningful during EXEC; a junk value elsewhere exposes any stray capture
  assign alu_out = in_exec ? alu_f(alu_opcode, alu_op1, alu_op2) : 12'hA5A;

  task automatic chk(string n, logic [11:0] a, logic [11:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cyc++;
    if (instr_valid && instr_ready) begin
      prev_acc = last_acc;
      last_acc = cyc;
    end
    chk("busy", 12'(busy), 12'(exp_busy));
    chk("ld_ready", 12'(ld_ready), 12'(!exp_busy));
    chk("instr_ready", 12'(instr_ready), 12'(!exp_busy && !ld_valid));
    chk("res_valid", 12'(res_valid), 12'(exp_rv));
    chk("alu_opcode", 12'(alu_opcode), 12'(exp_opc));
    chk("alu_op1", alu_op1, exp_op1);
    chk("alu_op2", alu_op2, exp_op2);
    if (exp_rv) begin
      chk("res_data", res_data, exp_res);
      chk("res_rd", 12'(res_rd), 12'(exp_rd));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(logic [1:0] a, logic [11:0] d);
    ld_valid = 1; ld_addr = a; ld_data = d;
    step;
    m[a] = d; ld_valid = 0;
  endtask

  task automatic issue(logic [2:0] o, logic [1:0] rd, logic [1:0] rs1, logic [1:0] rs2, int stall, bit rst_exec = 0);
    logic [11:0] r;
    instr_valid = 1; instr = {o, rd, rs1, rs2, 3'b101};
    step;
    instr_valid = 0; exp_busy = 1;
    step;
    exp_opc = o; exp_op1 = m[rs1]; exp_op2 = m[rs2]; in_exec = 1; res_ready = 0;
    ex_op1 = alu_op1; ex_op2 = alu_op2;
    if (rst_exec) begin
      rst_n = 0;
      #1;
      chk("rst busy", 12'(busy), 12'd0);
      chk("rst res_valid", 12'(res_valid), 12'd0);
      chk("rst alu_opcode", 12'(alu_opcode), 12'd0);
      chk("rst alu_op1", alu_op1, 12'd0);
      chk("rst alu_op2", alu_op2, 12'd0);
      in_exec = 0; exp_busy = 0; exp_rv = 0; exp_opc = 0; exp_op1 = 0; exp_op2 = 0;
      for (int i = 0; i < 4; i++) m[i] = 0;
      step;
      rst_n = 1;
      return;
    end
    r = alu_f(o, m[rs1], m[rs2]);
    step;
    in_exec = 0; m[rd] = r; exp_rv = 1; exp_res = r; exp_rd = rd;
    if (stall > 0) begin
      ld_valid = 1; ld_addr = rd; ld_data = 12'h777; instr_valid = 1;
      repeat (stall) step;
      ld_valid = 0; instr_valid = 0;
    end
    res_ready = 1; last_res = res_data;
    step;
    exp_busy = 0; exp_rv = 0; res_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; chk_en = 1;
    chk("reset res_data", res_data, 12'd0);
    chk("reset res_rd", 12'(res_rd), 12'd0);
    chk("reset instr_ready", 12'(instr_ready), 12'd1);
    chk("reset ld_ready", 12'(ld_ready), 12'd1);
    // basic add
    preload(2'd1, 12'h003);
    preload(2'd2, 12'h005);
    issue(3'd0, 2'd3, 2'd1, 2'd2, 0);
    chk("t1 op1", ex_op1, 12'h003);
    chk("t1 op2", ex_op2, 12'h005);
    chk("t1 res", last_res, 12'h008);
    issue(3'd5, 2'd3, 2'd3, 2'd3, 0);
    chk("t1 r3", last_res, 12'h008);
    // opcode sweep
    preload(2'd1, 12'h381);
    preload(2'd2, 12'h342);
    for (int o = 0; o < 8; o++) begin
      issue(3'(o), 2'd3, 2'd1, 2'd2, 0);
      if (o == 0) chk("sweep add", last_res, 12'h6C3);
      if (o == 4) chk("sweep xor", last_res, 12'h0C3);
      if (o == 7) chk("sweep not", last_res, 12'hC7E);
    end
    // backpressure, with ignored preload/instruction offered during the stall
    issue(3'd0, 2'd0, 2'd1, 2'd2, 5);
    chk("bp res", last_res, 12'h6C3);
    issue(3'd5, 2'd0, 2'd0, 2'd0, 0);
    chk("bp r0 once", last_res, 12'h6C3);
    // simultaneous preload and instruction
    ld_valid = 1; ld_addr = 2'd1; ld_data = 12'h006;
    instr_valid = 1; instr = {3'd0, 2'd2, 2'd1, 2'd1, 3'b000};
    step;
    m[1] = 12'h006; ld_valid = 0;
    issue(3'd0, 2'd2, 2'd1, 2'd1, 0);
    chk("simul res", last_res, 12'h00C);
    // dependent back-to-back
    preload(2'd1, 12'h004);
    preload(2'd2, 12'h008);
    issue(3'd0, 2'd0, 2'd1, 2'd2, 0);
    issue(3'd0, 2'd1, 2'd0, 2'd0, 0);
    chk("dep op1", ex_op1, 12'h00C);
    chk("dep op2", ex_op2, 12'h00C);
    chk("dep res", last_res, 12'h018);
    chk("dep interval", 12'(last_acc - prev_acc), 12'd4);
    // reset during EXEC, then all registers read back zero
    issue(3'd0, 2'd3, 2'd0, 2'd1, 0, 1);
    for (int r = 0; r < 4; r++) begin
      issue(3'd5, 2'(r), 2'(r), 2'(r), 0);
      chk("post-reset reg", last_res, 12'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
